// File: rtl/des_pkg.sv
// Shared types, widths and step helpers for the DES round sequencer.
package des_pkg;

   localparam int unsigned HALF_W     = 32;
   localparam int unsigned KEY_W      = 48;
   localparam int unsigned BLOCK_W    = 64;
   localparam int unsigned ROUND_W    = 5;
   localparam int unsigned DES_ROUNDS = 16;
   localparam int unsigned NUM_STEPS  = 6;

   typedef enum logic [3:0] {
      StIdle,
      StEx,
      StXr,
      StAr,
      StSb,
      StSp,
      StRd,
      StNext,
      StDone,
      StErr
   } state_e;

   // Strobe vector bit order, LSB first: ex, xr, ar, sb, sp, rd.
   typedef logic [NUM_STEPS-1:0] step_vec_t;

   function automatic step_vec_t step_strobe(input state_e st);
      step_vec_t v;
      case (st)
         StEx:    v = 6'b000001;
         StXr:    v = 6'b000010;
         StAr:    v = 6'b000100;
         StSb:    v = 6'b001000;
         StSp:    v = 6'b010000;
         StRd:    v = 6'b100000;
         default: v = 6'b000000;
      endcase
      return v;
   endfunction

   function automatic state_e step_next(input state_e st);
      state_e n;
      case (st)
         StEx:    n = StXr;
         StXr:    n = StAr;
         StAr:    n = StSb;
         StSb:    n = StSp;
         StSp:    n = StRd;
         StRd:    n = StNext;
         default: n = StIdle;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/des_step_timer.sv
// Per-step watchdog: counts cycles a strobe is held and flags expiry on the LIMIT-th cycle.
module des_step_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturates at LAST so a held strobe can never wrap back to a fresh count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/des_round_ctrl.sv
// DES round sequencer: steps the datapath strobes per round and feeds L/R back for NUM_ROUNDS.
// Optional macro DES_DECRYPT_EN adds a decrypt input that reverses the key-schedule round order.
module des_round_ctrl
   import des_pkg::*;
#(
   parameter int unsigned STEP_TIMEOUT = 16,
   parameter int unsigned NUM_ROUNDS   = DES_ROUNDS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BLOCK_W-1:0] block_in,
`ifdef DES_DECRYPT_EN
   input  logic               decrypt,
`endif
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [BLOCK_W-1:0] block_out,
   output logic [ROUND_W-1:0] round,
   output logic [HALF_W-1:0]  dp_left,
   output logic [HALF_W-1:0]  dp_right,
   output logic               dp_ex,
   output logic               dp_xr,
   output logic               dp_ar,
   output logic               dp_sb,
   output logic               dp_sp,
   output logic               dp_rd,
   input  logic               f_ex,
   input  logic               f_xr,
   input  logic               f_ar,
   input  logic               f_sb,
   input  logic               f_sp,
   input  logic               f_rd,
   input  logic [HALF_W-1:0]  rd_left,
   input  logic [HALF_W-1:0]  rd_right
);

   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

   state_e             state_q, state_d;
   logic               gap_q, gap_d;
   logic [HALF_W-1:0]  left_q, left_d;
   logic [HALF_W-1:0]  right_q, right_d;
   logic [ROUND_W-1:0] rc_q, rc_d;
   logic               err_q, err_d;
   logic               done_q, done_d;
   logic [BLOCK_W-1:0] blk_q, blk_d;

   step_vec_t strobe;
   step_vec_t flags;
   logic      step_active;
   logic      flag_hit;
   logic      step_expired;

   assign flags = {f_rd, f_sp, f_sb, f_ar, f_xr, f_ex};

   // gap_q marks the forced all-low cycle after a step's flag was accepted.
   always_comb begin
      strobe      = gap_q ? '0 : step_strobe(state_q);
      step_active = |strobe;
      flag_hit    = |(strobe & flags);
   end

   des_step_timer #(
      .LIMIT (STEP_TIMEOUT)
   ) u_step_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (!step_active),
      .en      (step_active),
      .expired (step_expired)
   );

`ifdef DES_DECRYPT_EN
   logic dec_q, dec_d;
`endif

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      left_d  = left_q;
      right_d = right_q;
      rc_d    = rc_q;
      err_d   = err_q;
      done_d  = 1'b0;
      blk_d   = blk_q;
`ifdef DES_DECRYPT_EN
      dec_d   = dec_q;
`endif
      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               left_d  = block_in[BLOCK_W-1:HALF_W];
               right_d = block_in[HALF_W-1:0];
               rc_d    = '0;
               err_d   = 1'b0;
               gap_d   = 1'b0;
`ifdef DES_DECRYPT_EN
               dec_d   = decrypt;
`endif
               state_d = StEx;
            end
         end
         StEx, StXr, StAr, StSb, StSp, StRd: begin
            if (gap_q) begin
               gap_d   = 1'b0;
               state_d = step_next(state_q);
            end else if (flag_hit) begin
               gap_d = 1'b1;
            end else if (step_expired) begin
               err_d   = 1'b1;
               state_d = StErr;
            end
         end
         StNext: begin
            left_d  = rd_left;
            right_d = rd_right;
            if (rc_q == LAST_ROUND) begin
               blk_d   = {rd_right, rd_left};
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               rc_d    = rc_q + ROUND_W'(1);
               state_d = StEx;
            end
         end
         default: begin
            state_d = StIdle;
            gap_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         gap_q   <= 1'b0;
         left_q  <= '0;
         right_q <= '0;
         rc_q    <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         left_q  <= left_d;
         right_q <= right_d;
         rc_q    <= rc_d;
         err_q   <= err_d;
         done_q  <= done_d;
         blk_q   <= blk_d;
      end
   end

`ifdef DES_DECRYPT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_q <= 1'b0;
      end else begin
         dec_q <= dec_d;
      end
   end

   assign round = dec_q ? (LAST_ROUND - rc_q) : rc_q;
`else
   assign round = rc_q;
`endif

   always_comb begin
      busy = !((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
      {dp_rd, dp_sp, dp_sb, dp_ar, dp_xr, dp_ex} = strobe;
   end

   assign done      = done_q;
   assign err       = err_q;
   assign block_out = blk_q;
   assign dp_left   = left_q;
   assign dp_right  = right_q;

endmodule

// File: doc/des_round_ctrl.md
Name: des_round_ctrl

Overview:
Sequencer for the single-round DES datapath (expansion, key XOR, S-box, P-box, round swap).
- Loads post-IP L0/R0, then steps the datapath strobes through one round at a time. Each step is handshaked on that stage's finish flag.
- Feeds each round's left/right back for 16 rounds and emits round indices to the key schedule.
- Presents the swapped pre-output block R16||L16 to the final permutation stage.

Parameters:
STEP_TIMEOUT, 16, max cycles a strobe is held waiting for its finish flag before aborting.
NUM_ROUNDS, 16, rounds per block (fixed 16 for DES; parameterised for reduced-round debug only).

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin a block; sampled only in IDLE/DONE/ERR.
block_in  in  64  post-IP block; L0=[63:32], R0=[31:0]; captured on accepted start.
busy  out  1  high from accepted start until DONE/ERR.
done  out  1  one-cycle pulse when block_out is valid.
err  out  1  sticky step-timeout flag; cleared by next accepted start.
block_out  out  64  {R16,L16}; held until next accepted start.
round  out  5  key-schedule round index for the current round.
dp_left, dp_right  out  32 each  leftPlain/rightPlain driven to the datapath.
dp_ex, dp_xr, dp_ar, dp_sb, dp_sp, dp_rd  out  1 each  datapath stage strobes.
f_ex, f_xr, f_ar, f_sb, f_sp, f_rd  in  1 each  datapath finish flags.
rd_left, rd_right  in  32 each  datapath round result (left=R(i-1), right=L(i-1)^f).

Behaviour:
- Reset: all outputs 0, state IDLE, round counter 0, timeout counter 0, internal L/R regs 0. Reset mid-block aborts immediately; no done pulse.
- States: IDLE, EX, XR, AR, SB, SP, RD, NEXT, DONE, ERR.
- IDLE/DONE/ERR + start=1: capture L=block_in[63:32], R=block_in[31:0], rc=0, clear err, busy=1, go EX.
- Step states (EX, XR, AR, SB, SP, RD) each assert exactly their own strobe; all other strobes stay 0 (one-hot or zero at all times).
- The strobe is held until the matching flag is sampled 1 at a posedge. The controller then drops the strobe and moves to the next step, giving a mandatory one-cycle all-strobes-low gap.
- Step order: EX→XR→AR→SB→SP→RD→NEXT.
- Flags for other stages are ignored; a flag high on strobe entry does not count until sampled while the strobe is asserted.
- Timeout counter clears on step entry and increments each cycle the strobe is held. When it reaches STEP_TIMEOUT with the flag still 0: drop all strobes, err=1, busy=0, go ERR. No done pulse; block_out unchanged.
- dp_left=L and dp_right=R are stable throughout the round.
- round = rc (encrypt order 0..15), stable from EX through RD.
- NEXT: L<=rd_left, R<=rd_right, then:
  - rc==NUM_ROUNDS-1: block_out<={rd_right,rd_left}, busy=0, done=1 for one cycle, go DONE.
  - otherwise rc<=rc+1, go EX.
- start while busy is ignored. DONE and ERR behave as IDLE for start.
- Latency: with each flag arriving one cycle after its strobe, every step takes 3 cycles (2 strobe + 1 gap). A round is therefore 6×3+1=19 cycles; block latency from start to done is 16×19+1 cycles.

Optional Feature:
DES_DECRYPT_EN
- With: extra input port decrypt (1 bit), captured on accepted start.
  - decrypt=1: round = 15−rc (reverse key order); everything else identical.
- Without: no decrypt port; round = rc always.

Decomposition:
- Package des_pkg holds: state enum type, NUM_ROUNDS default, 32/48/64-bit half/key/block width constants, round-index width.
- Natural sub-module: des_step_timer (per-step timeout counter with clear/expire), instantiated once.

Test Plan:
- Encrypt vector: block_in=CC00CCFF_F0AAF0AA, key schedule driven for key 133457799BBCDFF1, datapath model responding in 1 cycle → done after 16×19+1 cycles, block_out=0A4CD995_43423234, round visits 0..15.
- Strobe protocol: random flag delays 1–10 cycles → never two strobes high, one-cycle gap after every flag, L/R fed back correctly each round.
- Timeout: f_sb stuck 0 in round 3 → after STEP_TIMEOUT cycles, all strobes 0, err=1, busy=0, no done; next start clears err and completes normally.
- Reset mid-block: assert rst during round 7 SP step → all outputs 0 same cycle; post-reset start completes with correct result.
- start while busy: pulse start with a different block_in at round 5 → ignored, original result unchanged.
- DES_DECRYPT_EN build: decrypt=1, block_in=0A4CD995_43423234 (swap input halves) → round visits 15..0 and block_out swaps back to original L0/R0 (CC00CCFF_F0AAF0AA).
